fp4mac_sequencer: RTL and testbench

Job-level operand streamer and result collector that drives the FP4 multiply-accumulate datapath. It accepts a dot-product job of a given length, clears the MAC, and streams operand pairs from an upstream ready/valid source onto the MAC input valid/operand bus. It then counts returned accumulator updates until the pipeline drains and presents the final FP4 sum on a ready/valid result port. It sits between the operand fetch logic and the MAC, owning the MAC's input side and consuming its accumulator output.

---
 rtl/fp4mac_pkg.sv | 23 ++
 rtl/fp4mac_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fp4mac_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp4mac_pkg.sv
// Shared types and helpers for the FP4 (E2M1) MAC sequencer.
package fp4mac_pkg;

    typedef logic [3:0] fp4_t;

    // Job sequencer states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StIssue = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } seq_state_e;

    localparam fp4_t FP4_POS_ZERO = 4'b0000;
    localparam fp4_t FP4_NEG_ZERO = 4'b1000;

    // True for either signed zero encoding
    function automatic logic is_fp4_zero(input fp4_t v);
        return (v == FP4_POS_ZERO) || (v == FP4_NEG_ZERO);
    endfunction

endpackage

// File: rtl/fp4mac_sequencer.sv
// Job-level operand streamer / result collector for the FP4 MAC datapath.
// Clears the MAC, streams operand pairs, counts accumulator returns until the
// pipeline drains, then presents the final accumulator on a ready/valid port.
// Optional build macro: FP4SEQ_ZERO_SKIP_EN (pairs with a zero operand are
// consumed but not forwarded to the MAC).
module fp4mac_sequencer
    import fp4mac_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_idle,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [3:0]       i_op_a,
    input  logic [3:0]       i_op_b,
    output logic             o_mac_clr,
    output logic             o_mac_valid,
    output logic [3:0]       o_mac_a,
    output logic [3:0]       o_mac_b,
    input  logic             i_mac_valid,
    input  logic [3:0]       i_mac_accum,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [3:0]       o_res_data
);

    localparam logic [CNT_W-1:0] MaxLenC = CNT_W'(MAX_LEN);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] consumed_q, consumed_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] returned_q, returned_d;
    fp4_t             capture_q, capture_d;
    logic             mac_valid_q, mac_valid_d;
    fp4_t             mac_a_q, mac_a_d;
    fp4_t             mac_b_q, mac_b_d;

    logic             op_hs;
    logic             fwd;
    logic             ret_active;
    logic [CNT_W-1:0] len_clamped;

    assign len_clamped = (i_len > MaxLenC) ? MaxLenC : i_len;
    assign op_hs       = (state_q == StIssue) && i_op_valid;
    assign ret_active  = (state_q == StIssue) || (state_q == StDrain);

`ifdef FP4SEQ_ZERO_SKIP_EN
    assign fwd = op_hs && !is_fp4_zero(i_op_a) && !is_fp4_zero(i_op_b);
`else
    assign fwd = op_hs;
`endif

    // Next-state, counters, capture and MAC operand register logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        consumed_d  = consumed_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        capture_d   = capture_q;
        mac_valid_d = fwd;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;

        if (fwd) begin
            mac_a_d = i_op_a;
            mac_b_d = i_op_b;
        end

        // A return in this cycle counts toward the drain decision below
        if (ret_active && i_mac_valid) begin
            capture_d = i_mac_accum;
            if (returned_q < issued_q) begin
                returned_d = returned_q + CNT_W'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StClear;
                    len_d      = len_clamped;
                    consumed_d = '0;
                    issued_d   = '0;
                    returned_d = '0;
                    capture_d  = '0;
                end
            end
            StClear: begin
                state_d = (len_q == '0) ? StDrain : StIssue;
            end
            StIssue: begin
                if (op_hs) begin
                    consumed_d = consumed_q + CNT_W'(1);
                    if (consumed_q + CNT_W'(1) == len_q) begin
                        state_d = StDrain;
                    end
                end
                if (fwd) begin
                    issued_d = issued_q + CNT_W'(1);
                end
            end
            StDrain: begin
                if (returned_d == issued_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            consumed_q  <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            capture_q   <= '0;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            consumed_q  <= consumed_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            capture_q   <= capture_d;
            mac_valid_q <= mac_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        o_idle      = (state_q == StIdle);
        o_mac_clr   = (state_q == StClear);
        o_op_ready  = (state_q == StIssue);
        o_res_valid = (state_q == StDone);
        o_res_data  = (state_q == StDone) ? capture_q : 4'b0000;
        o_mac_valid = mac_valid_q;
        o_mac_a     = mac_a_q;
        o_mac_b     = mac_b_q;
    end

endmodule

// File: tb/tb_fp4mac_sequencer.sv
// Self-checking bench for fp4mac_sequencer with a behavioural FP4 MAC model.
// Honours FP4SEQ_ZERO_SKIP_EN when the design is built with it.
module tb_fp4mac_sequencer;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             o_idle;
    logic             i_op_valid;
    logic             o_op_ready;
    logic [3:0]       i_op_a, i_op_b;
    logic             o_mac_clr, o_mac_valid;
    logic [3:0]       o_mac_a, o_mac_b;
    logic             i_mac_valid;
    logic [3:0]       i_mac_accum;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [3:0]       o_res_data;

    int total = 0;
    int bad   = 0;
    int pulses, rets;
    logic [7:0] exp_q[$];
    logic [3:0] res_q[$];

    always #5 clk = ~clk;

    fp4mac_sequencer #(.MAX_LEN(MAX_LEN)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_len      (i_len),
        .o_idle     (o_idle),
        .i_op_valid (i_op_valid),
        .o_op_ready (o_op_ready),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_mac_clr  (o_mac_clr),
        .o_mac_valid(o_mac_valid),
        .o_mac_a    (o_mac_a),
        .o_mac_b    (o_mac_b),
        .i_mac_valid(i_mac_valid),
        .i_mac_accum(i_mac_accum),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_data (o_res_data)
    );

    // FP4 magnitude in quarter units: 0,0.5,1,1.5,2,3,4,6
    function automatic int mag_q(input logic [2:0] m);
        case (m)
            3'd0: return 0;   3'd1: return 2;   3'd2: return 4;   3'd3: return 6;
            3'd4: return 8;   3'd5: return 12;  3'd6: return 16;  default: return 24;
        endcase
    endfunction

    // Product in quarter units (half-unit * half-unit)
    function automatic int qprod(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = (mag_q(a[2:0]) / 2) * (mag_q(b[2:0]) / 2);
        return (a[3] ^ b[3]) ? -p : p;
    endfunction

    // Nearest FP4 encoding of a quarter-unit value
    function automatic logic [3:0] enc(input int q);
        int m, best;
        logic [2:0] bi;
        m = (q < 0) ? -q : q;
        best = 0;
        for (int i = 1; i < 8; i++) begin
            bi = 3'(i);
            if ((mag_q(bi) - m) * (mag_q(bi) - m) <
                (mag_q(3'(best)) - m) * (mag_q(3'(best)) - m)) best = i;
        end
        return {q < 0, 3'(best)};
    endfunction

    function automatic logic zero4(input logic [3:0] v);
        return v[2:0] == 3'b000;
    endfunction

    // Two-stage MAC model; clear flushes in-flight pairs
    logic mv1 = 1'b0, mv2 = 1'b0;
    int   prod1 = 0, acc = 0;
    always @(posedge clk) begin
        if (rst || o_mac_clr) begin
            mv1 <= 1'b0;
            mv2 <= 1'b0;
            acc <= 0;
        end else begin
            mv1   <= o_mac_valid;
            prod1 <= qprod(o_mac_a, o_mac_b);
            mv2   <= mv1;
            if (mv1) acc <= acc + prod1;
        end
    end
    assign i_mac_valid = mv2;
    assign i_mac_accum = enc(acc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Operand scoreboard: pairs pushed at handshake, popped on o_mac_valid
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (o_mac_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("mac_unexpected", 32'(o_mac_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mac_ops", 32'({o_mac_a, o_mac_b}), 32'(e));
                end
            end
            if (i_mac_valid) rets++;
        end
    end

    typedef struct {
        int              len_in;
        int              n_pairs;
        logic [15:0][3:0] a;
        logic [15:0][3:0] b;
        logic [3:0]      exp_res;
        int              exp_pulses;
        int              gap;
        int              hold;
    } job_t;

    function automatic job_t mk(input int len_in, input int n, input logic [3:0] r,
                                input int p, input int gap, input int hold);
        job_t j;
        j.len_in = len_in;  j.n_pairs = n;  j.exp_res = r;  j.exp_pulses = p;
        j.gap = gap;        j.hold = hold;  j.a = '0;       j.b = '0;
        return j;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input job_t j);
        int idx, cyc;
        logic [3:0] r0;
        logic fwd;
        logic [31:0] lv;
        pulses = 0;
        rets   = 0;
        res_q.push_back(j.exp_res);
        lv = 32'(j.len_in);
        i_len   = lv[CNT_W-1:0];
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("clr_t1", 32'(o_mac_clr), 32'd1);
        chk("idle_t1", 32'(o_idle), 32'd0);
        step();
        chk("clr_once", 32'(o_mac_clr), 32'd0);
        chk("ready_t2", 32'(o_op_ready), 32'(j.n_pairs > 0));
        idx = 0;
        cyc = 0;
        while (idx < j.n_pairs && cyc < 200) begin
            i_op_valid = (j.gap == 0) || (cyc % 2 == 0);
            i_op_a = j.a[idx];
            i_op_b = j.b[idx];
            if (i_op_valid && o_op_ready) begin
                fwd = 1'b1;
`ifdef FP4SEQ_ZERO_SKIP_EN
                fwd = !zero4(i_op_a) && !zero4(i_op_b);
`endif
                if (fwd) exp_q.push_back({i_op_a, i_op_b});
                idx++;
            end
            step();
            cyc++;
        end
        i_op_valid = 1'b0;
        chk("pairs_fed", 32'(idx), 32'(j.n_pairs));
        if (j.gap == 0) chk("no_stall", 32'(cyc), 32'(j.n_pairs));
        if (j.n_pairs > 0) chk("ready_drop", 32'(o_op_ready), 32'd0);
        cyc = 0;
        while (!o_res_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk("res_timeout", 32'(o_res_valid), 32'd1);
        chk("returns", 32'(rets), 32'(j.exp_pulses));
        chk("pulses", 32'(pulses), 32'(j.exp_pulses));
        r0 = o_res_data;
        for (int h = 0; h < j.hold; h++) begin
            i_start = 1'b1;
            chk("hold_valid", 32'(o_res_valid), 32'd1);
            chk("hold_data", 32'(o_res_data), 32'(r0));
            chk("hold_idle", 32'(o_idle), 32'd0);
            step();
        end
        i_start     = 1'b0;
        i_res_ready = 1'b1;
        chk("res_data", 32'(o_res_data), 32'(res_q.pop_front()));
        step();
        i_res_ready = 1'b0;
        chk("idle_after", 32'(o_idle), 32'd1);
        chk("res_drop", 32'(o_res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[5];
        int   zp;
`ifdef FP4SEQ_ZERO_SKIP_EN
        zp = 1;
`else
        zp = 3;
`endif
        jobs[0] = mk(2, 2, 4'b0101, 2, 0, 5);
        jobs[0].a[0] = 4'b0010;  jobs[0].b[0] = 4'b0010;
        jobs[0].a[1] = 4'b0010;  jobs[0].b[1] = 4'b0100;
        jobs[1] = mk(0, 0, 4'b0000, 0, 0, 0);
        jobs[2] = mk(4, 4, 4'b0110, 4, 1, 0);
        jobs[3] = mk(31, 16, 4'b0110, 16, 0, 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                jobs[2].a[i] = 4'b0010;
                jobs[2].b[i] = 4'b0010;
            end
            jobs[3].a[i] = 4'b0001;
            jobs[3].b[i] = 4'b0001;
        end
        jobs[4] = mk(3, 3, 4'b0100, zp, 0, 0);
        jobs[4].a[0] = 4'b0000;  jobs[4].b[0] = 4'b0110;
        jobs[4].a[1] = 4'b1000;  jobs[4].b[1] = 4'b0010;
        jobs[4].a[2] = 4'b0010;  jobs[4].b[2] = 4'b0100;

        rst = 1'b1;  i_start = 1'b0;  i_len = '0;  i_op_valid = 1'b0;
        i_op_a = '0; i_op_b = '0;     i_res_ready = 1'b0;
        pulses = 0;  rets = 0;
        repeat (3) step();
        chk("rst_idle", 32'(o_idle), 32'd1);
        chk("rst_ready", 32'(o_op_ready), 32'd0);
        chk("rst_clr", 32'(o_mac_clr), 32'd0);
        chk("rst_mac_valid", 32'(o_mac_valid), 32'd0);
        chk("rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("rst_mac_ab", 32'({o_mac_a, o_mac_b}), 32'd0);
        chk("rst_res_data", 32'(o_res_data), 32'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) run_job(jobs[k]);

        // Reset in the middle of ISSUE abandons the job
        i_len = CNT_W'(4);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_op_valid = 1'b1;
        i_op_a = 4'b0010;  i_op_b = 4'b0010;
        exp_q.push_back({i_op_a, i_op_b});
        step();
        i_op_a = 4'b0010;  i_op_b = 4'b0100;
        exp_q.push_back({i_op_a, i_op_b});
        step();
        i_op_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_idle", 32'(o_idle), 32'd1);
        chk("mid_rst_ready", 32'(o_op_ready), 32'd0);
        chk("mid_rst_mac_valid", 32'(o_mac_valid), 32'd0);
        chk("mid_rst_clr", 32'(o_mac_clr), 32'd0);
        chk("mid_rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("mid_rst_mac_ab", 32'({o_mac_a, o_mac_b}), 32'd0);
        chk("mid_rst_res_data", 32'(o_res_data), 32'd0);
        chk("mid_rst_exp_q", 32'(exp_q.size()), 32'd0);
        step();

        jobs[0] = mk(1, 1, 4'b0010, 1, 0, 0);
        jobs[0].a[0] = 4'b0010;  jobs[0].b[0] = 4'b0010;
        run_job(jobs[0]);

        repeat (4) step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
